// File: rtl/cmp_pkg.sv
// Shared types and default sizing for the sequential wide comparator.
package cmp_pkg;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; keeps at least one bit when there is a single chunk.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned slice comparator.
module cmp_chunk #(
    parameter int CHUNK = cmp_pkg::DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_seq_256.sv
// Sequential WIDTH-bit unsigned comparator, one CHUNK slice per cycle, MSB slice first.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to finish on the first differing slice.
module comparator_seq_256 #(
    parameter int WIDTH = cmp_pkg::DEF_WIDTH,
    parameter int CHUNK = cmp_pkg::DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             greater,
    output logic             less,
    output logic             equal
);
    import cmp_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_bits(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           r_state, w_state_next;
    logic             r_active;
    logic [WIDTH-1:0] r_a, r_b, w_a_next, w_b_next;
    logic [IW-1:0]    r_idx, w_idx_next;
    logic             r_gt, r_lt, w_gt_next, w_lt_next;

    logic [CHUNK-1:0] w_a_sl [NCHUNK];
    logic [CHUNK-1:0] w_b_sl [NCHUNK];
    logic             w_sl_gt, w_sl_lt, w_sl_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign w_a_sl[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_sl[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (w_a_sl[r_idx]),
        .b  (w_b_sl[r_idx]),
        .gt (w_sl_gt),
        .lt (w_sl_lt),
        .eq (w_sl_eq)
    );

    // r_active keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_active <= 1'b1;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_idx    <= w_idx_next;
            r_gt     <= w_gt_next;
            r_lt     <= w_lt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_idx_next   = r_idx;
        w_gt_next    = r_gt;
        w_lt_next    = r_lt;
        case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_a_next     = a;
                    w_b_next     = b;
                    w_idx_next   = LAST_IDX;
                    w_gt_next    = 1'b0;
                    w_lt_next    = 1'b0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // The first differing slice decides; later slices cannot change it.
                if (!r_gt && !r_lt && !w_sl_eq) begin
                    w_gt_next = w_sl_gt;
                    w_lt_next = w_sl_lt;
                end
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
                if (!w_sl_eq || (r_idx == '0)) begin
`else
                if (r_idx == '0) begin
`endif
                    w_state_next = DONE;
                end else begin
                    w_idx_next = r_idx - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready  = r_active && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign greater   = out_valid && r_gt;
    assign less      = out_valid && r_lt;
    assign equal     = out_valid && !r_gt && !r_lt;

endmodule

// File: tb/tb_comparator_seq_256.sv
// Bench for comparator_seq_256: directed vectors plus a per-cycle reference model.
module tb_comparator_seq_256;

    localparam int W = 256;
    localparam int C = 16;
    localparam int N = W / C;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready, out_valid, greater, less, equal;

    int n_vec  = 0;
    int n_miss = 0;

    comparator_seq_256 #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .greater   (greater),
        .less      (less),
        .equal     (equal)
    );

    always #5 clk = ~clk;

    // {greater, less, equal} from a plain unsigned compare.
    function automatic logic [2:0] mdl_flags(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int mdl_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        if (!EE) return N;
        for (int k = N - 1; k >= 0; k--) begin
            if (x[k*C +: C] != y[k*C +: C]) return N - k;
        end
        return N;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 0 = waiting for request, 1 = busy counting down, 2 = result held.
    int         m_phase = 0;
    bit         m_act   = 1'b0;
    int         m_left  = 0;
    logic [2:0] m_flags = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_act   <= 1'b0;
            m_left  <= 0;
            m_flags <= 3'b000;
        end else begin
            m_act <= 1'b1;
            case (m_phase)
                0: if (m_act && in_valid) begin
                    m_flags <= mdl_flags(a, b);
                    m_left  <= mdl_lat(a, b);
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp_v;
        exp_v = {(m_phase == 0) && m_act, m_phase == 2, (m_phase == 2) ? m_flags : 3'b000};
        check("cycle", {27'd0, in_ready, out_valid, greater, less, equal}, {27'd0, exp_v});
    end

    task automatic run_txn(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [2:0] exp_flags, input int exp_lat, input int hold);
        int cyc;
        cyc = 0;
        out_ready = (hold == 0);
        while (in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (in_ready !== 1'b1) begin
            check({name, "_ready_timeout"}, 0, 1);
            return;
        end
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(negedge clk);
        // Scramble operands and keep in_valid high while busy; both must be ignored.
        a = {8{$urandom()}};
        b = {8{$urandom()}};
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) begin
            check({name, "_done_timeout"}, 0, 1);
            return;
        end
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_flags"}, {29'd0, greater, less, equal}, {29'd0, exp_flags});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold"}, {29'd0, in_ready, out_valid, greater | less | equal},
                  {29'd0, 3'b011});
            check({name, "_hold_flags"}, {29'd0, greater, less, equal}, {29'd0, exp_flags});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_back_idle"}, {30'd0, in_ready, out_valid}, {30'd0, 2'b10});
    endtask

    logic [W-1:0] va, vb;

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        check("release_pre_edge", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("release_post_edge", {31'd0, in_ready}, 1);

        // Pin the model against hand-computed values.
        va = '0; vb = '0;
        va[255:240] = 16'hF81A; vb[255:240] = 16'hC28F;
        check("pin_top_flags", {29'd0, mdl_flags(va, vb)}, {29'd0, 3'b100});
        check("pin_top_lat", mdl_lat(va, vb), EE ? 1 : 16);
        va = '0; vb = '0;
        va[127:112] = 16'h7C98; vb[127:112] = 16'h7C28;
        check("pin_s7_lat", mdl_lat(va, vb), EE ? 9 : 16);
        check("pin_zero_flags", {29'd0, mdl_flags('0, '0)}, {29'd0, 3'b001});

        run_txn("zeros", '0, '0, 3'b001, 16, 0);

        va = '0; vb = '0;
        va[255:240] = 16'hF81A; vb[255:240] = 16'hC28F;
        run_txn("top_slice", va, vb, 3'b100, EE ? 1 : 16, 10);

        va = {16{16'h5A5A}}; vb = va;
        va[15:0] = 16'hAA9C; vb[15:0] = 16'hD7A0;
        run_txn("low_slice", va, vb, 3'b010, 16, 0);

        va = '0; vb = '0;
        va[127:112] = 16'h7C98; vb[127:112] = 16'h7C28;
        vb[15:0] = 16'hFFFF;
        run_txn("slice7", va, vb, 3'b100, EE ? 9 : 16, 2);

        // Reset in the middle of a scan: that request must never produce a result.
        va = '0; vb = '0;
        va[15:0] = 16'h0001;
        out_ready = 1'b1;
        a = va; b = vb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", {27'd0, in_ready, out_valid, greater, less, equal}, 0);
        end
        #2 rst_n = 1'b1;
        check("rst_release_pre", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("rst_release_post", {31'd0, in_ready}, 1);
        repeat (20) begin
            @(negedge clk);
            check("rst_no_result", {31'd0, out_valid}, 0);
        end

        va = '0; vb = '0;
        va[255:240] = 16'h0001; vb[255:240] = 16'h0002;
        run_txn("after_reset", va, vb, 3'b010, EE ? 1 : 16, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/comparator_seq_256.md
COMPARATOR_SEQ_256 -- requirements
Module: comparator_seq_256

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request holds a valid operand pair.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port out_valid  output  1  result flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port greater  output  1  A > B.
REQ-012 SHALL have port less  output  1  A < B.
REQ-013 SHALL have port equal  output  1  A == B.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on in_valid&&in_ready, latch a and b, set the chunk index to WIDTH/CHUNK-1 (MSB chunk), and enter RUN.
REQ-017 SHALL, in RUN, compare one CHUNK-wide slice per cycle, MSB slice first, decrementing the index.
REQ-018 SHALL leave RUN when the index reaches 0; DONE carries the final flags.
REQ-019 SHALL leave RUN immediately on the first unequal slice when EARLY_EXIT_EN is defined.
REQ-020 SHALL, in DONE, hold out_valid=1 and stable flags until out_ready=1.
REQ-021 SHALL go from DONE to IDLE on out_valid&&out_ready, with in_ready=1 on the following cycle.
REQ-022 SHALL produce worst-case latency from the accept edge to out_valid of WIDTH/CHUNK cycles (16 at defaults).
REQ-023 SHALL assert exactly one of greater/less/equal while out_valid=1 and all three =0 otherwise.
REQ-024 SHALL ignore a and b changes after the accept edge.
REQ-025 SHALL ignore in_valid outside IDLE.
REQ-026 SHALL ignore out_ready outside DONE.
REQ-027 SHALL, when out_ready is held at 1, still insert one IDLE cycle between results (no accept in DONE).

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-RUN or in DONE, immediately force IDLE, abandon the in-flight comparison and produce no output for it.
REQ-029 SHALL, during reset, force out_valid=0, greater=0, less=0, equal=0 and in_ready=0.
REQ-030 SHALL drive in_ready=1 on the first clk edge after rst_n release.

Configuration
REQ-031 SHALL use the macro COMPARATOR_SEQ_EARLY_EXIT_EN to select early termination.
REQ-032 SHALL, with COMPARATOR_SEQ_EARLY_EXIT_EN defined, enter DONE the cycle after the first differing slice; latency = (WIDTH/CHUNK - index_of_first_diff) cycles.
REQ-033 SHALL, without COMPARATOR_SEQ_EARLY_EXIT_EN, scan all slices, freeze the decision at the first differing slice, and use the fixed latency WIDTH/CHUNK.

Structure
REQ-034 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/CHUNK constants in the shared package cmp_pkg.
REQ-035 SHALL instantiate one sub-module, cmp_chunk, a combinational CHUNK-bit slice comparator with gt/lt/eq outputs.

Verification
REQ-036 SHALL verify: reset mid-RUN (assert rst_n=0 at cycle 5 after accept) -> out_valid stays 0; in_ready=1 one edge after release.
REQ-037 SHALL verify: a=b=0 -> equal=1 after exactly 16 cycles, both configurations.
REQ-038 SHALL verify: a[255:240]=16'hF81A, b[255:240]=16'hC28F, rest 0 -> greater=1; latency 1 with macro, 16 without.
REQ-039 SHALL verify: a[15:0]=16'hAA9C, b[15:0]=16'hD7A0, rest equal -> less=1; latency 16 both configurations.
REQ-040 SHALL verify: slice 7 a=16'h7C98, b=16'h7C28, higher slices equal -> greater=1; latency 9 with macro.
REQ-041 SHALL verify: out_ready held 0 for 10 cycles -> flags stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, a new request is accepted.
